// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches one word per strobe over a
// request/valid memory port and signals completion to the controller on en1.
module instr_fetch_unit #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_fetch_pulse,
    input  logic               en_pc_pulse,
    input  logic [1:0]         pc_ctrl,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               err_clr,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_rvalid,
    output logic               en1,
    output logic [3:0]         opcode,
    output logic [1:0]         rd,
    output logic [1:0]         rs,
    output logic [7:0]         imm,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               fetch_err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [PC_W-1:0]      r_mem_addr, w_mem_addr_nxt;
    logic [INSTR_W-1:0]   r_ir, w_ir_nxt;
    logic                 r_en1, w_en1_nxt;
    logic                 r_mem_req, w_mem_req_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_fetch_err, w_fetch_err_nxt;
    logic                 w_err_set;
    logic [PC_W-1:0]      r_pc;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_ir        <= '0;
            r_en1       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_busy      <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_ir        <= w_ir_nxt;
            r_en1       <= w_en1_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_busy      <= w_busy_nxt;
            r_fetch_err <= w_fetch_err_nxt;
        end
    end

    // Next-state and output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_mem_addr_nxt = r_mem_addr;
        w_ir_nxt       = r_ir;
        w_en1_nxt      = r_en1;
        w_err_set      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (en_fetch_pulse) begin
                    w_mem_addr_nxt = r_pc;
                    w_en1_nxt      = 1'b0;
                    w_state_nxt    = S_REQ;
                end
            end
            S_REQ: begin
                w_err_set   = en_fetch_pulse;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_err_set = en_fetch_pulse;
                if (mem_rvalid) begin
                    w_ir_nxt    = mem_rdata;
                    w_en1_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // Abort: complete with an empty instruction and flag it
                    w_ir_nxt    = '0;
                    w_en1_nxt   = 1'b1;
                    w_err_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A set event in the same cycle as err_clr keeps the flag set
        w_fetch_err_nxt = w_err_set | (r_fetch_err & ~err_clr);
        w_mem_req_nxt   = (w_state_nxt == S_REQ);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    // PC update runs independently of the fetch state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (en_pc_pulse) begin
            case (pc_ctrl)
                2'b01:   r_pc <= r_pc + PC_W'(1);
                2'b10:   r_pc <= branch_target;
                2'b11:   r_pc <= '0;
                default: r_pc <= r_pc;
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign en1       = r_en1;
    assign opcode    = r_ir[15:12];
    assign rd        = r_ir[11:10];
    assign rs        = r_ir[9:8];
    assign imm       = r_ir[7:0];
    assign pc        = r_pc;
    assign busy      = r_busy;
    assign fetch_err = r_fetch_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// fetch/PC traffic checked against a transaction-level model.
module tb_instr_fetch_unit;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned TIMEOUT = 15;

    logic               clk;
    logic               rst_n;
    logic               en_fetch_pulse;
    logic               en_pc_pulse;
    logic [1:0]         pc_ctrl;
    logic [PC_W-1:0]    branch_target;
    logic               err_clr;
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_rvalid;
    logic               en1;
    logic [3:0]         opcode;
    logic [1:0]         rd;
    logic [1:0]         rs;
    logic [7:0]         imm;
    logic [PC_W-1:0]    pc;
    logic               busy;
    logic               fetch_err;

    instr_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .en_fetch_pulse(en_fetch_pulse), .en_pc_pulse(en_pc_pulse),
        .pc_ctrl(pc_ctrl), .branch_target(branch_target), .err_clr(err_clr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .en1(en1), .opcode(opcode), .rd(rd), .rs(rs),
        .imm(imm), .pc(pc), .busy(busy), .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural state only
    int          m_pc;
    logic [15:0] m_ir;
    bit          m_en1;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pc_next(input int p, input logic [1:0] ctrl, input int tgt);
        case (ctrl)
            2'b01:   return (p + 1) % 256;
            2'b10:   return tgt;
            2'b11:   return 0;
            default: return p;
        endcase
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, "_en1"}, en1, m_en1);
        chk({tag, "_ir"}, {opcode, rd, rs, imm}, m_ir);
        chk({tag, "_err"}, fetch_err, m_err);
        chk({tag, "_pc"}, pc, m_pc);
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = '0; m_en1 = 0; m_err = 0;
    endtask

    task automatic pc_op(input logic [1:0] ctrl, input logic [7:0] tgt);
        en_pc_pulse = 1'b1; pc_ctrl = ctrl; branch_target = tgt;
        tick();
        en_pc_pulse = 1'b0;
        m_pc = pc_next(m_pc, ctrl, int'(tgt));
        chk("pc_op", pc, m_pc);
    endtask

    // One full fetch; dly = WAIT cycles before rvalid (>= TIMEOUT means none)
    task automatic do_fetch(input bit pc_en, input logic [1:0] ctrl, input logic [7:0] tgt,
                            input int dly, input logic [15:0] data,
                            input int extra_at, input bit extra_clr);
        int  exp_addr;
        bit  extra;
        bit  done;
        exp_addr = m_pc;
        chk("pre_en1_hold", en1, m_en1);
        en_fetch_pulse = 1'b1; en_pc_pulse = pc_en; pc_ctrl = ctrl; branch_target = tgt;
        tick();
        en_fetch_pulse = 1'b0; en_pc_pulse = 1'b0;
        if (pc_en) m_pc = pc_next(m_pc, ctrl, int'(tgt));
        m_en1 = 0;
        chk("req_hi", mem_req, 1);
        chk("req_addr", mem_addr, exp_addr);
        chk("req_en1", en1, 0);
        chk("req_busy", busy, 1);
        chk("req_pc", pc, m_pc);
        // Data offered during the request cycle must be ignored
        mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
        tick();
        chk("req_one_cycle", mem_req, 0);
        done = 0;
        for (int k = 0; k < int'(TIMEOUT); k++) begin
            extra = (k == extra_at);
            en_fetch_pulse = extra;
            err_clr = extra & extra_clr;
            if (k == dly) begin mem_rvalid = 1'b1; mem_rdata = data; end
            else begin mem_rvalid = 1'b0; mem_rdata = 16'($urandom); end
            tick();
            en_fetch_pulse = 1'b0; err_clr = 1'b0; mem_rvalid = 1'b0;
            if (extra) m_err = 1;
            if (k == dly) begin
                m_ir = data; m_en1 = 1; done = 1;
            end else if (k == int'(TIMEOUT) - 1) begin
                m_ir = '0; m_en1 = 1; m_err = 1; done = 1;
            end
            chk_state("wait");
            chk("wait_no_req", mem_req, 0);
            chk("wait_busy", busy, !done);
            chk("wait_addr", mem_addr, exp_addr);
            if (done) break;
        end
    endtask

    task automatic idle_cycle();
        mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
        tick();
        mem_rvalid = 1'b0;
        chk_state("idle");
        chk("idle_busy", busy, 0);
    endtask

    task automatic clear_err(input bit clr);
        err_clr = clr;
        tick();
        err_clr = 1'b0;
        if (clr) m_err = 0;
        chk("err_clr", fetch_err, m_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en_fetch_pulse = 1'b0; en_pc_pulse = 1'b0; pc_ctrl = 2'b00;
        branch_target = '0; err_clr = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
        model_reset();
        tick(); tick();
        chk("rst_outs", {mem_req, mem_addr, en1, opcode, rd, rs, imm, pc, busy, fetch_err}, 0);
        rst_n = 1'b1;
        tick();

        // Fetch at pc 0 with increment; data returns two cycles after mem_req
        do_fetch(1, 2'b01, 8'h00, 1, 16'h1A3C, -1, 0);
        chk("t1_opcode", opcode, 4'h1);
        chk("t1_rd", rd, 2'd2);
        chk("t1_rs", rs, 2'd2);
        chk("t1_imm", imm, 8'h3C);
        chk("t1_pc", pc, 8'h01);

        // PC wrap, branch, clear, hold
        pc_op(2'b10, 8'hFF);
        pc_op(2'b01, 8'h00);
        pc_op(2'b10, 8'h40);
        pc_op(2'b11, 8'h77);
        pc_op(2'b10, 8'h21);
        pc_op(2'b00, 8'h99);

        // Timeout, then clear the sticky error
        do_fetch(0, 2'b00, 8'h00, int'(TIMEOUT) + 3, 16'hBEEF, -1, 0);
        chk("t3_ir_zero", {opcode, rd, rs, imm}, 0);
        chk("t3_err", fetch_err, 1);
        clear_err(1);

        // Second strobe while waiting (with a competing clear)
        do_fetch(0, 2'b00, 8'h00, 4, 16'h5A96, 2, 1);
        chk("t4_err", fetch_err, 1);
        clear_err(1);

        // Reset mid-fetch, then stray rvalid
        en_fetch_pulse = 1'b1;
        tick();
        en_fetch_pulse = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_async", {mem_req, en1, busy, pc, fetch_err}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 16'hFFFF;
        tick();
        mem_rvalid = 1'b0;
        chk_state("t5");
        chk("t5_busy", busy, 0);

        // Back-to-back fetches at pc 3 and 4
        pc_op(2'b10, 8'h03);
        do_fetch(1, 2'b01, 8'h00, 0, 16'h3C11, -1, 0);
        do_fetch(1, 2'b01, 8'h00, 4, 16'h7E42, -1, 0);
        chk("t6_pc", pc, 8'h05);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 6) begin
                int dly;
                int xat;
                dly = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, TIMEOUT + 2))
                                                  : int'($urandom_range(0, 6));
                xat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
                do_fetch(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom),
                         dly, 16'($urandom), xat, 1'($urandom_range(0, 1)));
            end else if (sel < 8) begin
                pc_op(2'($urandom), 8'($urandom));
            end else if (sel == 8) begin
                idle_cycle();
            end else begin
                clear_err(1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Responder side of the controller's fetch/PC handshake.
- Owns the program counter (PC) and the instruction register (IR).
- On each fetch strobe it reads one instruction word from instruction memory over a request/valid interface, latches it, decodes the fields, and reports completion to the control FSM on en1.
- Sits between the control state machine and instruction memory; its decoded opcode and rd feed back into the controller.

Parameters:
PC_W, 8, program counter and memory address width
INSTR_W, 16, instruction word width; field layout below is fixed for 16
TIMEOUT, 15, max WAIT cycles without mem_rvalid before the fetch is aborted (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
en_fetch_pulse  in  1  one-cycle fetch strobe from the controller
en_pc_pulse  in  1  one-cycle PC update strobe
pc_ctrl  in  2  PC op: 00 hold, 01 increment, 10 load branch_target, 11 clear to 0
branch_target  in  PC_W  PC value loaded when pc_ctrl=10
err_clr  in  1  synchronous clear of fetch_err
mem_req  out  1  read request, one cycle per fetch
mem_addr  out  PC_W  read address, stable from mem_req until the fetch ends
mem_rdata  in  INSTR_W  read data, valid when mem_rvalid=1
mem_rvalid  in  1  read data valid
en1  out  1  fetch done (level); instruction fields valid
opcode  out  4  IR[15:12]
rd  out  2  IR[11:10]
rs  out  2  IR[9:8]
imm  out  8  IR[7:0]
pc  out  PC_W  current PC
busy  out  1  high in REQ or WAIT
fetch_err  out  1  sticky error flag

Behaviour:
Reset (async, rst_n low): all outputs are 0, including pc, IR, en1, mem_req, mem_addr, fetch_err. State goes to IDLE and the timeout counter to 0. Reset applied mid-fetch abandons the fetch; any later mem_rvalid is ignored because the state is then IDLE.

FSM states: IDLE, REQ, WAIT.
- IDLE, en_fetch_pulse=1: mem_addr <= pc (the pre-update value), en1 <= 0, next state REQ.
- REQ: mem_req=1 for exactly this cycle. Next state WAIT, counter <= 0. mem_rvalid in REQ is ignored.
- WAIT, mem_rvalid=1: IR <= mem_rdata, en1 <= 1, next state IDLE.
- WAIT, no mem_rvalid: counter increments. If counter==TIMEOUT-1, abort: IR <= 0, en1 <= 1, fetch_err <= 1, next state IDLE.
- mem_rvalid seen in IDLE: ignored.

Latency:
- Pulse sampled at edge 0. mem_req is high in cycle 1.
- rvalid arrives earliest in cycle 2; en1 rises in cycle 3.
- en1 = 1 cycle after the cycle in which rvalid is seen in WAIT.

en1 and outputs:
- en1 stays high until the next accepted en_fetch_pulse.
- opcode, rd, rs and imm are continuous decodes of IR and hold their value between fetches.
- mem_req is a registered output.

PC update (on the en_pc_pulse edge, independent of FSM state):
- pc_ctrl=01: pc <= pc+1, wrapping modulo 2^PC_W (0xFF -> 0x00).
- pc_ctrl=10: pc <= branch_target.
- pc_ctrl=11: pc <= 0.
- pc_ctrl=00: hold.

Simultaneous fetch and PC pulses (the normal controller case):
- The fetch uses the old PC.
- The PC updates on the same edge.
- Example: pc=5 with both pulses and pc_ctrl=01 gives mem_addr=5, then pc=6.

Error conditions:
- en_fetch_pulse while busy: ignored for fetching; fetch_err <= 1; the in-flight fetch continues.
- Timeout: as described under WAIT above.
- fetch_err clears only on err_clr=1. If a set event and err_clr=1 occur in the same cycle, the set wins.

Test Plan:
1. Reset, then en_fetch_pulse + en_pc_pulse with pc_ctrl=01; memory returns 16'h1A3C two cycles after mem_req -> mem_addr=0, pc=1, en1 rises one cycle after rvalid, opcode=1, rd=2, rs=2, imm=8'h3C.
2. pc=8'hFF with en_pc_pulse and pc_ctrl=01 -> pc=0. pc_ctrl=10 with branch_target=8'h40 -> pc=8'h40. pc_ctrl=11 -> pc=0. pc_ctrl=00 -> pc unchanged.
3. Memory never asserts rvalid, TIMEOUT=15 -> after 15 WAIT cycles en1=1, IR=0, fetch_err=1, busy=0. err_clr pulse -> fetch_err=0.
4. Second en_fetch_pulse during WAIT -> no second mem_req, fetch_err=1, first fetch completes normally with the correct IR.
5. Assert rst_n low during WAIT, release, then mem_rvalid=1 with data 16'hFFFF -> IR stays 0, en1=0, state IDLE.
6. Back-to-back fetches at pc=3 then pc=4 with rvalid delays of 1 and 5 cycles -> en1 drops on the second accepted pulse, mem_addr=4 for the second fetch, IR updates only on the second rvalid.
